// File: rtl/signal_param_meter_pkg.sv
// Shared constants and types for the signal parameter meter.
//   DUTY_SCALE  per-mille full scale for duty
//   PARAM_W     width of the published freq/duty words
//   FREQ_SAT    saturation value of the rising-edge counter
//   GATE_W      width of gate/high-time counters (GATE_CYCLES < 2^27)
//   NUM_W       divider numerator width (high_cnt * 1000)
//   DIV_CYCLES  cycles the sequential divider needs, one per quotient bit
//   meas_state_e  gate-window FSM states
package signal_param_meter_pkg;

   localparam int unsigned DUTY_SCALE = 1000;
   localparam int unsigned PARAM_W    = 16;
   localparam logic [PARAM_W-1:0] FREQ_SAT = 16'hFFFF;
   localparam int unsigned GATE_W     = 27;
   localparam int unsigned NUM_W      = 37;
   localparam int unsigned DIV_CYCLES = NUM_W;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } meas_state_e;

endpackage

// File: rtl/signal_param_meter_if.sv
// Bus between the measurement block and its environment.
//   meas_enable  run gate windows while high
//   sig_in       asynchronous digitised test signal
//   freq/duty    last window's edge count and per-mille duty
//   freq_ovf     last window saturated freq
//   param_valid  1-cycle strobe when freq/duty/freq_ovf update
//   busy         gate window or division in progress
// master drives the controls and reads results; slave is the meter.
interface signal_param_meter_if;
   import signal_param_meter_pkg::*;

   logic               meas_enable;
   logic               sig_in;
   logic [PARAM_W-1:0] freq;
   logic [PARAM_W-1:0] duty;
   logic               freq_ovf;
   logic               param_valid;
   logic               busy;

   modport master (output meas_enable, sig_in,
                   input  freq, duty, freq_ovf, param_valid, busy);
   modport slave  (input  meas_enable, sig_in,
                   output freq, duty, freq_ovf, param_valid, busy);
endinterface

// File: rtl/signal_param_meter_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//   clk, rst  clock and synchronous active-high reset
//   start     load num/den and begin (ignored bits of a running divide are lost)
//   num, den  NUM_W-bit numerator, DEN_W-bit denominator
//   quo       quotient, valid while done is high
//   active    division in progress
//   done      1-cycle strobe, NUM_W cycles after the start cycle's edge
module seq_divider #(
   parameter int NUM_W = 37,
   parameter int DEN_W = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic [NUM_W-1:0] quo,
   output logic             active,
   output logic             done
);
   localparam int CNT_W = $clog2(NUM_W);

   // numerator bits leave at the top while quotient bits enter at the bottom
   logic [NUM_W-1:0] shift_q;
   logic [DEN_W-1:0] rem_q;
   logic [DEN_W-1:0] den_q;
   logic [CNT_W-1:0] bit_cnt;
   logic [DEN_W:0]   trial;
   logic             take;
   logic [DEN_W-1:0] rem_nxt;

   always_comb begin
      trial   = {rem_q, shift_q[NUM_W-1]};
      take    = (trial >= {1'b0, den_q});
      rem_nxt = take ? DEN_W'(trial - {1'b0, den_q}) : trial[DEN_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         done    <= 1'b0;
         bit_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            active  <= 1'b1;
            bit_cnt <= '0;
         end else if (active) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(NUM_W - 1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         shift_q <= num;
         rem_q   <= '0;
         den_q   <= den;
      end else if (active) begin
         shift_q <= {shift_q[NUM_W-2:0], take};
         rem_q   <= rem_nxt;
      end
   end

   assign quo = shift_q;
endmodule

// File: rtl/signal_param_meter.sv
// Gate-window frequency / duty meter.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  slave side of signal_param_meter_if (meas_enable, sig_in in;
//        freq, duty, freq_ovf, param_valid, busy out)
// Back-to-back windows of GATE_CYCLES clocks count rising edges and high
// cycles of the synchronised input; each closed window is converted to
// per-mille duty by seq_divider and published with a 1-cycle strobe.
module signal_param_meter
   import signal_param_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   signal_param_meter_if.slave  bus
);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_DEN  = GATE_W'(GATE_CYCLES);

   function automatic logic [PARAM_W:0] count_edge(input logic [PARAM_W-1:0] cnt,
                                                   input logic ovf, input logic rise_i);
      // returns {ovf, cnt}; the edge counter sticks at FREQ_SAT
      if (!rise_i)             return {ovf, cnt};
      else if (cnt == FREQ_SAT) return {1'b1, cnt};
      else                      return {ovf, cnt + 1'b1};
   endfunction

   function automatic logic [PARAM_W-1:0] clamp_duty(input logic [NUM_W-1:0] q);
      if (q > NUM_W'(DUTY_SCALE)) return PARAM_W'(DUTY_SCALE);
      else                        return q[PARAM_W-1:0];
   endfunction

   meas_state_e        state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_chain;
   logic               s, s_d, rise;
   logic [GATE_W-1:0]  gate_cnt, high_cnt, high_nxt;
   logic [PARAM_W-1:0] edge_cnt, edge_nxt, freq_snap;
   logic               ovf_acc, ovf_nxt, ovf_snap;
   logic               counting, win_close;
   logic [NUM_W-1:0]   div_num, div_quo;
   logic               div_active, div_done;
   logic [PARAM_W-1:0] freq_q, duty_q;
   logic               ovf_q, valid_q;

   // ---- input synchroniser and edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_chain <= '0;
         s_d        <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], bus.sig_in};
         s_d        <= s;
      end
   end

   assign s    = sync_chain[SYNC_STAGES-1];
   assign rise = s & ~s_d;

   // ---- gate-window FSM
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.meas_enable)  state_nxt = GATE;
         GATE:    if (!bus.meas_enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- window counters; the closing cycle's rise/s go into the snapshot
   always_comb begin
      counting            = (state == GATE) && bus.meas_enable;
      win_close           = counting && (gate_cnt == GATE_LAST);
      {ovf_nxt, edge_nxt} = count_edge(edge_cnt, ovf_acc, rise);
      high_nxt            = high_cnt + GATE_W'(s);
      div_num             = NUM_W'(high_nxt) * NUM_W'(DUTY_SCALE);
   end

   always_ff @(posedge clk) begin
      if (rst || win_close || !counting) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf_acc  <= 1'b0;
         high_cnt <= '0;
      end else begin
         gate_cnt <= gate_cnt + 1'b1;
         edge_cnt <= edge_nxt;
         ovf_acc  <= ovf_nxt;
         high_cnt <= high_nxt;
      end
   end

   // snapshot is consumed DIV_CYCLES+1 cycles later, long before the next close
   always_ff @(posedge clk) begin
      if (win_close) begin
         freq_snap <= edge_nxt;
         ovf_snap  <= ovf_nxt;
      end
   end

   seq_divider #(
      .NUM_W (NUM_W),
      .DEN_W (GATE_W)
   ) u_div (
      .clk    (clk),
      .rst    (rst),
      .start  (win_close),
      .num    (div_num),
      .den    (GATE_DEN),
      .quo    (div_quo),
      .active (div_active),
      .done   (div_done)
   );

   // ---- publish registers
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_q  <= '0;
         duty_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= div_done;
         if (div_done) begin
            freq_q <= freq_snap;
            ovf_q  <= ovf_snap;
            duty_q <= clamp_duty(div_quo);
         end
      end
   end

   assign bus.freq        = freq_q;
   assign bus.duty        = duty_q;
   assign bus.freq_ovf    = ovf_q;
   assign bus.param_valid = valid_q;
   assign bus.busy        = (state == GATE) | div_active;
endmodule
